// File: rtl/out_port_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : out_port_buffer_pkg
//  Brief    : Shared sizing defaults for the router output-port flit buffer.
//  Revision : 1.0  initial release
// ============================================================================
package out_port_buffer_pkg;

    localparam int c_flit_w     = 32;
    localparam int c_opb_depth  = 4;
    localparam int c_opb_af_lvl = 3;

endpackage : out_port_buffer_pkg
`default_nettype wire

// File: rtl/out_port_buffer_sync_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : out_port_buffer_sync_fifo_mem
//  Brief    : DEPTH x FLIT_W register array, synchronous write, async read.
//  Revision : 1.0  initial release
// ============================================================================
module out_port_buffer_sync_fifo_mem #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [FLIT_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [FLIT_W-1:0] rdata
);

    // Storage is deliberately not reset; occupancy lives in the pointers.
    logic [FLIT_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : out_port_buffer_sync_fifo_mem
`default_nettype wire

// File: rtl/out_port_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : out_port_buffer
//  Brief    : Per-output-port flit FIFO between crossbar and inter-router link.
//  Revision : 1.0  initial release
// ============================================================================
module out_port_buffer
    import out_port_buffer_pkg::*;
#(
    parameter int FLIT_W = c_flit_w,
    parameter int DEPTH  = c_opb_depth,
    parameter int AF_LVL = c_opb_af_lvl
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [FLIT_W-1:0]        wr_flit,
    output logic                     full,
    output logic                     almost_full,
    output logic                     link_valid,
    output logic [FLIT_W-1:0]        link_flit,
    input  logic                     link_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_err
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_ovf_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Flags decode only the count register, so a pop never frees a slot
    // for a push in the same cycle.
    assign w_full  = (r_count == c_cnt_w'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en & ~w_full;
    assign w_pop   = ~w_empty & link_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (wr_en && w_full) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    out_port_buffer_sync_fifo_mem #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ptr_w)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (wr_flit),
        .raddr (r_rd_ptr),
        .rdata (link_flit)
    );

    assign full        = w_full;
    assign almost_full = (r_count >= c_cnt_w'(AF_LVL));
    assign link_valid  = ~w_empty;
    assign count       = r_count;
    assign ovf_err     = r_ovf_err;

endmodule : out_port_buffer
`default_nettype wire

// File: tb/tb_out_port_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_out_port_buffer
//  Brief    : Directed stimulus with a queue scoreboard on the link handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_out_port_buffer;

    localparam int c_flit_w = 32;
    localparam int c_depth  = 4;
    localparam int c_af_lvl = 3;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       wr_en;
    logic [c_flit_w-1:0]        wr_flit;
    logic                       full;
    logic                       almost_full;
    logic                       link_valid;
    logic [c_flit_w-1:0]        link_flit;
    logic                       link_ready;
    logic [$clog2(c_depth):0]   count;
    logic                       ovf_err;

    int n_vec = 0;
    int n_err = 0;
    logic [c_flit_w-1:0] exp_q[$];

    out_port_buffer #(
        .FLIT_W (c_flit_w),
        .DEPTH  (c_depth),
        .AF_LVL (c_af_lvl)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_flit     (wr_flit),
        .full        (full),
        .almost_full (almost_full),
        .link_valid  (link_valid),
        .link_flit   (link_flit),
        .link_ready  (link_ready),
        .count       (count),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && link_valid === 1'b1 && link_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL link_unexpected: got %h expected no flit", link_flit);
                end else begin
                    check("link_flit", link_flit, exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_flit    = '0;
        link_ready = 1'b0;
        exp_q.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [31:0] flit, input bit accepted);
        wr_en   = 1'b1;
        wr_flit = flit;
        if (accepted) exp_q.push_back(flit);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        link_ready = 1'b1;
        for (int i = 0; i < budget && count != 0; i++) cyc();
        link_ready = 1'b0;
        check("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_flit    = '0;
        link_ready = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(link_valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_ovf", 32'(ovf_err), 32'd0);
        reset_dut();

        // Reset mid-stream with three flits queued
        wr(32'hAAAA_0001, 1'b0);
        wr(32'hAAAA_0002, 1'b0);
        wr(32'hAAAA_0003, 1'b0);
        check("pre_rst_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(link_valid), 32'd0);
        check("mid_rst_full", 32'(full), 32'd0);
        cyc();
        rst_n = 1'b1;
        wr(32'hA5A5_0001, 1'b1);
        check("post_rst_valid", 32'(link_valid), 32'd1);
        check("post_rst_flit", link_flit, 32'hA5A5_0001);
        drain(4);

        // Fill to full, then overflow
        reset_dut();
        wr(32'h1, 1'b1);
        wr(32'h2, 1'b1);
        check("fill2_afull", 32'(almost_full), 32'd0);
        wr(32'h3, 1'b1);
        check("fill3_afull", 32'(almost_full), 32'd1);
        check("fill3_full", 32'(full), 32'd0);
        wr(32'h4, 1'b1);
        check("fill4_full", 32'(full), 32'd1);
        check("fill4_count", 32'(count), 32'd4);
        check("fill4_ovf", 32'(ovf_err), 32'd0);
        wr(32'h5, 1'b0);
        check("ovf_set", 32'(ovf_err), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        drain(8);
        check("ovf_sticky", 32'(ovf_err), 32'd1);

        // Full with simultaneous write and pop: pop only
        reset_dut();
        for (int i = 0; i < 4; i++) wr(32'h10 + 32'(i), 1'b1);
        wr_en      = 1'b1;
        wr_flit    = 32'hDEAD_BEEF;
        link_ready = 1'b1;
        cyc();
        wr_en      = 1'b0;
        link_ready = 1'b0;
        check("fullpp_count", 32'(count), 32'd3);
        check("fullpp_ovf", 32'(ovf_err), 32'd1);
        drain(8);

        // Stall: head must hold while not accepted
        reset_dut();
        wr(32'h77, 1'b1);
        wr(32'h78, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("stall_flit", link_flit, 32'h77);
            check("stall_count", 32'(count), 32'd2);
        end
        drain(8);

        // Stream: simultaneous push and pop keeps occupancy at one
        reset_dut();
        link_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_en   = 1'b1;
            wr_flit = 32'h100 + 32'(i);
            exp_q.push_back(wr_flit);
            cyc();
            check("stream_count", 32'(count), 32'd1);
            check("stream_full", 32'(full), 32'd0);
        end
        wr_en = 1'b0;
        drain(4);

        // Wrap: three rounds of push 3 / pop 3
        reset_dut();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) wr(32'h200 + 32'(r * 3 + i), 1'b1);
            check("wrap_count", 32'(count), 32'd3);
            drain(6);
        end
        check("wrap_ovf", 32'(ovf_err), 32'd0);

        cyc();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule : tb_out_port_buffer
`default_nettype wire
